// File: rtl/stack_prog_sequencer_pkg.sv
// Shared definitions for the stack program sequencer.
// Holds the opcode encodings, the ALU control words driven on alu_ctrl,
// and the controller state type.
package stack_prog_sequencer_pkg;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_PUSHI = 4'h1;
   localparam logic [3:0] OP_ADD   = 4'h2;
   localparam logic [3:0] OP_SUB   = 4'h3;
   localparam logic [3:0] OP_POP   = 4'h4;
   localparam logic [3:0] OP_JMP   = 4'h5;
   localparam logic [3:0] OP_JZ    = 4'h6;
   localparam logic [3:0] OP_JS    = 4'h7;
   localparam logic [3:0] OP_HALT  = 4'hF;

   localparam logic [3:0] ALU_CTRL_ADD = 4'b0111;
   localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EXEC,
      ST_ALU_WAIT,
      ST_HALT,
      ST_ERROR
   } state_e;

endpackage

// File: rtl/stack_prog_sequencer_if.sv
// Bus bundle between the sequencer and its surroundings: instruction ROM
// port, ALU control/flags/stack requests, and the shared stack port.
//   master : sequencer side (drives imem_addr, alu_en, alu_ctrl, stk_*)
//   slave  : ROM / ALU / stack side
interface stack_prog_sequencer_if #(
   parameter int unsigned DATA_LEN = 8,
   parameter int unsigned ADDR_LEN = 6
);
   logic [ADDR_LEN-1:0]   imem_addr;
   logic [DATA_LEN+3:0]   imem_data;
   logic                  alu_en;
   logic [3:0]            alu_ctrl;
   logic                  alu_z_flag;
   logic                  alu_s_flag;
   logic                  alu_stk_push;
   logic                  alu_stk_pop;
   logic [DATA_LEN-1:0]   alu_stk_data_in;
   logic                  stk_push;
   logic                  stk_pop;
   logic [DATA_LEN-1:0]   stk_data_in;

   modport master (
      output imem_addr, alu_en, alu_ctrl, stk_push, stk_pop, stk_data_in,
      input  imem_data, alu_z_flag, alu_s_flag,
             alu_stk_push, alu_stk_pop, alu_stk_data_in
   );

   modport slave (
      input  imem_addr, alu_en, alu_ctrl, stk_push, stk_pop, stk_data_in,
      output imem_data, alu_z_flag, alu_s_flag,
             alu_stk_push, alu_stk_pop, alu_stk_data_in
   );
endinterface

// File: rtl/stack_prog_sequencer_stk_port_mux.sv
// Stack port mux: while the ALU owns the stack (alu_sel=1) its push/pop/data
// requests reach the stack, otherwise the controller's do. Only one source
// is ever forwarded in a given cycle.
//   alu_sel            : 1 = ALU owns the stack port
//   ctl_* / alu_*      : candidate push/pop/data from each source
//   stk_push/pop/data  : muxed stack port
module stk_port_mux #(
   parameter int unsigned DATA_LEN = 8
) (
   input  logic                alu_sel,
   input  logic                ctl_push,
   input  logic                ctl_pop,
   input  logic [DATA_LEN-1:0] ctl_data,
   input  logic                alu_push,
   input  logic                alu_pop,
   input  logic [DATA_LEN-1:0] alu_data,
   output logic                stk_push,
   output logic                stk_pop,
   output logic [DATA_LEN-1:0] stk_data
);
   always_comb begin
      if (alu_sel) begin
         stk_push = alu_push;
         stk_pop  = alu_pop;
         stk_data = alu_data;
      end else begin
         stk_push = ctl_push;
         stk_pop  = ctl_pop;
         stk_data = ctl_data;
      end
   end
endmodule

// File: rtl/stack_prog_sequencer.sv
// Program sequencer for the stack datapath. Fetches from a synchronous ROM,
// executes PUSHI/POP on the stack, launches the ALU for ADD/SUB and lends it
// the stack port, tracks depth and resolves JZ/JS on the latched ALU flags.
//   clk, rstn  : clock, async active-low reset
//   start      : begin at pc=0 (only seen in IDLE)
//   bus        : ROM / ALU / stack bundle (master side)
//   busy       : program running
//   halted     : HALT executed
//   error      : illegal opcode or stack over/underflow
//   pc         : current program counter
module stack_prog_sequencer
   import stack_prog_sequencer_pkg::*;
#(
   parameter int unsigned DATA_LEN   = 8,
   parameter int unsigned ADDR_LEN   = 6,
   parameter int unsigned STK_DEPTH  = 16,
   parameter int unsigned ALU_CYCLES = 10
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      start,
   stack_prog_sequencer_if.master    bus,
   output logic                      busy,
   output logic                      halted,
   output logic                      error,
   output logic [ADDR_LEN-1:0]       pc
);
   localparam int unsigned DEPTH_W = $clog2(STK_DEPTH + 1);
   localparam int unsigned CNT_W   = $clog2(ALU_CYCLES + 1);
   localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STK_DEPTH);
   localparam logic [DEPTH_W-1:0] DEPTH_TWO  = DEPTH_W'(2);

   state_e               state_q, state_d;
   logic [ADDR_LEN-1:0]  pc_q, pc_d;
   logic [DEPTH_W-1:0]   depth_q, depth_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [3:0]           ctrl_q, ctrl_d;
   logic                 z_q, z_d, s_q, s_d;

   logic [3:0]           opcode;
   logic [DATA_LEN-1:0]  operand;
   logic [ADDR_LEN-1:0]  pc_inc, target;
   logic                 ctl_push, ctl_pop;
   logic [DATA_LEN-1:0]  ctl_data;

   assign opcode  = bus.imem_data[DATA_LEN+3:DATA_LEN];
   assign operand = bus.imem_data[DATA_LEN-1:0];
   assign pc_inc  = pc_q + 1'b1;
   assign target  = operand[ADDR_LEN-1:0];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         depth_q <= '0;
         cnt_q   <= '0;
         ctrl_q  <= '0;
         z_q     <= 1'b0;
         s_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         depth_q <= depth_d;
         cnt_q   <= cnt_d;
         ctrl_q  <= ctrl_d;
         z_q     <= z_d;
         s_q     <= s_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      depth_d = depth_q;
      cnt_d   = cnt_q;
      ctrl_d  = ctrl_q;
      z_d     = z_q;
      s_d     = s_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FETCH;
               pc_d    = '0;
            end
         end
         ST_FETCH: state_d = ST_EXEC;
         ST_EXEC: begin
            state_d = ST_FETCH;
            case (opcode)
               OP_NOP: pc_d = pc_inc;
               OP_PUSHI: begin
                  if (depth_q == DEPTH_FULL) state_d = ST_ERROR;
                  else begin
                     depth_d = depth_q + 1'b1;
                     pc_d    = pc_inc;
                  end
               end
               OP_POP: begin
                  if (depth_q == '0) state_d = ST_ERROR;
                  else begin
                     depth_d = depth_q - 1'b1;
                     pc_d    = pc_inc;
                  end
               end
               OP_ADD, OP_SUB: begin
                  if (depth_q < DEPTH_TWO) state_d = ST_ERROR;
                  else begin
                     state_d = ST_ALU_WAIT;
                     cnt_d   = CNT_W'(ALU_CYCLES - 1);
                     ctrl_d  = (opcode == OP_ADD) ? ALU_CTRL_ADD : ALU_CTRL_SUB;
                  end
               end
               OP_JMP:  pc_d = target;
               OP_JZ:   pc_d = z_q ? target : pc_inc;
               OP_JS:   pc_d = s_q ? target : pc_inc;
               OP_HALT: state_d = ST_HALT;
               default: state_d = ST_ERROR;
            endcase
         end
         ST_ALU_WAIT: begin
            if (cnt_q == '0) begin
               // Two operands popped, one result pushed: net depth -1.
               z_d     = bus.alu_z_flag;
               s_d     = bus.alu_s_flag;
               depth_d = depth_q - 1'b1;
               pc_d    = pc_inc;
               state_d = ST_FETCH;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = state_q;
      endcase
   end

   always_comb begin
      ctl_push     = 1'b0;
      ctl_pop      = 1'b0;
      ctl_data     = '0;
      bus.alu_en   = 1'b0;
      bus.alu_ctrl = '0;
      case (state_q)
         ST_EXEC: begin
            case (opcode)
               OP_PUSHI: begin
                  if (depth_q != DEPTH_FULL) begin
                     ctl_push = 1'b1;
                     ctl_data = operand;
                  end
               end
               OP_POP: ctl_pop = (depth_q != '0);
               OP_ADD, OP_SUB: begin
                  if (depth_q >= DEPTH_TWO) begin
                     bus.alu_en   = 1'b1;
                     bus.alu_ctrl = (opcode == OP_ADD) ? ALU_CTRL_ADD : ALU_CTRL_SUB;
                  end
               end
               default: ;
            endcase
         end
         ST_ALU_WAIT: bus.alu_ctrl = ctrl_q;
         default: ;
      endcase
   end

   assign busy          = (state_q == ST_FETCH) || (state_q == ST_EXEC) ||
                          (state_q == ST_ALU_WAIT);
   assign halted        = (state_q == ST_HALT);
   assign error         = (state_q == ST_ERROR);
   assign pc            = pc_q;
   assign bus.imem_addr = pc_q;

   stk_port_mux #(.DATA_LEN(DATA_LEN)) u_stk_port_mux (
      .alu_sel  (state_q == ST_ALU_WAIT),
      .ctl_push (ctl_push),
      .ctl_pop  (ctl_pop),
      .ctl_data (ctl_data),
      .alu_push (bus.alu_stk_push),
      .alu_pop  (bus.alu_stk_pop),
      .alu_data (bus.alu_stk_data_in),
      .stk_push (bus.stk_push),
      .stk_pop  (bus.stk_pop),
      .stk_data (bus.stk_data_in)
   );
endmodule

// File: tb/tb_stack_prog_sequencer.sv
module tb_stack_prog_sequencer;
   import stack_prog_sequencer_pkg::*;

   localparam int DL = 8;
   localparam int AL = 6;
   localparam int SD = 16;
   localparam int AC = 10;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          start = 1'b0;
   logic          busy, halted, error;
   logic [AL-1:0] pc;

   stack_prog_sequencer_if #(.DATA_LEN(DL), .ADDR_LEN(AL)) bus ();

   stack_prog_sequencer #(.DATA_LEN(DL), .ADDR_LEN(AL), .STK_DEPTH(SD),
                          .ALU_CYCLES(AC)) dut (
      .clk(clk), .rstn(rstn), .start(start), .bus(bus),
      .busy(busy), .halted(halted), .error(error), .pc(pc)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Instruction ROM (one-cycle read latency)
   logic [DL+3:0] rom [64];
   always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

   function automatic logic [DL+3:0] ins(input logic [3:0] op, input logic [DL-1:0] arg);
      return {op, arg};
   endfunction

   // Behavioural stack and ALU: pops top (op1) in cycle 1, second in cycle 2,
   // pushes the result in cycle 9, flags valid from cycle 9.
   logic [DL-1:0] mem [32];
   int            sp;
   int            alu_cnt;
   logic [3:0]    alu_op;
   logic [DL-1:0] op1, op2, alu_res;
   logic          push_force = 1'b0;

   assign alu_res             = (alu_op == ALU_CTRL_SUB) ? op1 - op2 : op1 + op2;
   assign bus.alu_stk_pop     = (alu_cnt == 1) || (alu_cnt == 2);
   assign bus.alu_stk_push    = (alu_cnt == 9) || push_force;
   assign bus.alu_stk_data_in = alu_res;
   assign bus.alu_z_flag      = (alu_cnt >= 9) && (alu_res == '0);
   assign bus.alu_s_flag      = (alu_cnt >= 9) && alu_res[DL-1];

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sp      <= 0;
         alu_cnt <= 0;
         alu_op  <= '0;
         op1     <= '0;
         op2     <= '0;
      end else begin
         if (bus.stk_push && sp < 32) begin
            mem[sp] <= bus.stk_data_in;
            sp      <= sp + 1;
         end else if (bus.stk_pop && sp > 0) begin
            sp <= sp - 1;
         end
         if (alu_cnt == 1 && sp > 0) op1 <= mem[sp-1];
         if (alu_cnt == 2 && sp > 0) op2 <= mem[sp-1];
         if (bus.alu_en) begin
            alu_cnt <= 1;
            alu_op  <= bus.alu_ctrl;
         end else if (alu_cnt == 10) alu_cnt <= 0;
         else if (alu_cnt != 0) alu_cnt <= alu_cnt + 1;
      end
   end

   // Scoreboard: expected push data queued by the stimulus, checked on each push.
   logic [DL-1:0] exp_q [$];
   int push_cnt = 0, pop_cnt = 0, alu_en_cnt = 0;

   always @(negedge clk) begin
      if (rstn) begin
         if (bus.stk_push) begin
            push_cnt++;
            if (exp_q.size() == 0) check("push_unexpected", 32'(bus.stk_data_in), 32'hDEAD);
            else check("push_data", 32'(bus.stk_data_in), 32'(exp_q.pop_front()));
         end
         if (bus.stk_pop) pop_cnt++;
         if (bus.alu_en) alu_en_cnt++;
      end
   end

   task automatic clear_rom();
      for (int i = 0; i < 64; i++) rom[i] = ins(OP_HALT, 8'h00);
   endtask

   task automatic do_reset();
      @(negedge clk);
      start = 1'b0;
      push_force = 1'b0;
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic kick();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 2000; i++) begin
         @(posedge clk);
         #1;
         if (halted || error) return;
      end
      check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   int p0, q0, a0;

   initial begin
      // Reset state
      clear_rom();
      do_reset();
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
      check("rst_push", 32'(bus.stk_push), 32'd0);

      // PUSHI 5, PUSHI 3, SUB, HALT -> 3-5 = FE
      clear_rom();
      rom[0] = ins(OP_PUSHI, 8'd5);
      rom[1] = ins(OP_PUSHI, 8'd3);
      rom[2] = ins(OP_SUB, 8'd0);
      rom[3] = ins(OP_HALT, 8'd0);
      exp_q.push_back(8'd5); exp_q.push_back(8'd3); exp_q.push_back(8'hFE);
      do_reset();
      kick();
      check("t1_busy", 32'(busy), 32'd1);
      wait_done("t1");
      check("t1_halted", 32'(halted), 32'd1);
      check("t1_busy_end", 32'(busy), 32'd0);
      check("t1_pc", 32'(pc), 32'd3);
      check("t1_depth", 32'(dut.depth_q), 32'd1);
      check("t1_s", 32'(dut.s_q), 32'd1);
      check("t1_z", 32'(dut.z_q), 32'd0);
      check("t1_sp", 32'(sp), 32'd1);
      check("t1_top", 32'(mem[0]), 32'hFE);
      check("t1_queue", 32'(exp_q.size()), 32'd0);

      // Zero result steers JZ
      clear_rom();
      rom[0] = ins(OP_PUSHI, 8'd4);
      rom[1] = ins(OP_PUSHI, 8'd4);
      rom[2] = ins(OP_SUB, 8'd0);
      rom[3] = ins(OP_JZ, 8'd6);
      rom[4] = ins(OP_PUSHI, 8'd1);
      rom[5] = ins(OP_HALT, 8'd0);
      rom[6] = ins(OP_PUSHI, 8'd9);
      rom[7] = ins(OP_HALT, 8'd0);
      exp_q.push_back(8'd4); exp_q.push_back(8'd4);
      exp_q.push_back(8'd0); exp_q.push_back(8'd9);
      do_reset();
      kick();
      wait_done("t2");
      check("t2_halted", 32'(halted), 32'd1);
      check("t2_pc", 32'(pc), 32'd7);
      check("t2_z", 32'(dut.z_q), 32'd1);
      check("t2_sp", 32'(sp), 32'd2);
      check("t2_bottom", 32'(mem[0]), 32'd0);
      check("t2_top", 32'(mem[1]), 32'd9);
      check("t2_queue", 32'(exp_q.size()), 32'd0);

      // POP on empty stack: error two cycles after start is taken
      clear_rom();
      rom[0] = ins(OP_POP, 8'd0);
      do_reset();
      q0 = pop_cnt;
      @(negedge clk) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("t3_fetch_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      check("t3_exec_error", 32'(error), 32'd0);
      @(posedge clk); #1;
      check("t3_error", 32'(error), 32'd1);
      check("t3_busy", 32'(busy), 32'd0);
      check("t3_pc", 32'(pc), 32'd0);
      check("t3_pops", 32'(pop_cnt - q0), 32'd0);

      // Overflow on the 17th PUSHI
      clear_rom();
      for (int i = 0; i <= SD; i++) rom[i] = ins(OP_PUSHI, 8'(i + 1));
      for (int i = 0; i < SD; i++) exp_q.push_back(8'(i + 1));
      do_reset();
      p0 = push_cnt;
      kick();
      wait_done("t4");
      check("t4_error", 32'(error), 32'd1);
      check("t4_halted", 32'(halted), 32'd0);
      check("t4_depth", 32'(dut.depth_q), 32'(SD));
      check("t4_pushes", 32'(push_cnt - p0), 32'(SD));
      check("t4_pc", 32'(pc), 32'(SD));
      check("t4_queue", 32'(exp_q.size()), 32'd0);

      // Illegal opcode
      clear_rom();
      rom[0] = 12'hA00;
      do_reset();
      p0 = push_cnt; q0 = pop_cnt; a0 = alu_en_cnt;
      kick();
      wait_done("t5");
      check("t5_error", 32'(error), 32'd1);
      check("t5_pc", 32'(pc), 32'd0);
      check("t5_activity", 32'((push_cnt - p0) + (pop_cnt - q0) + (alu_en_cnt - a0)), 32'd0);

      // Async reset in ALU_WAIT cycle 4
      clear_rom();
      rom[0] = ins(OP_PUSHI, 8'd1);
      rom[1] = ins(OP_PUSHI, 8'd2);
      rom[2] = ins(OP_ADD, 8'd0);
      exp_q.push_back(8'd1); exp_q.push_back(8'd2);
      do_reset();
      kick();
      begin : find_alu_en
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.alu_en) disable find_alu_en;
         end
         check("t6_alu_en_timeout", 32'd0, 32'd1);
      end
      check("t6_alu_ctrl_exec", 32'(bus.alu_ctrl), 32'(ALU_CTRL_ADD));
      repeat (4) @(posedge clk);
      #1;
      check("t6_alu_ctrl_wait", 32'(bus.alu_ctrl), 32'(ALU_CTRL_ADD));
      check("t6_alu_en_wait", 32'(bus.alu_en), 32'd0);
      #1 rstn = 1'b0;
      #1;
      check("t6_state", 32'(dut.state_q), 32'(ST_IDLE));
      check("t6_outs", 32'({busy, halted, error, bus.alu_en, bus.stk_push, bus.stk_pop}), 32'd0);
      check("t6_pc", 32'(pc), 32'd0);
      check("t6_addr", 32'(bus.imem_addr), 32'd0);
      check("t6_ctrl", 32'(bus.alu_ctrl), 32'd0);
      check("t6_data", 32'(bus.stk_data_in), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      push_force = 1'b1;
      p0 = push_cnt;
      repeat (3) @(negedge clk);
      check("t6_no_forward", 32'(bus.stk_push), 32'd0);
      check("t6_pushes", 32'(push_cnt - p0), 32'd0);
      push_force = 1'b0;
      check("t6_queue", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
